uc_multiciclo: RTL

UC_MULTICICLO -- requirements
Module: uc_multiciclo

---
 rtl/uc_pkg.sv | 104 ++++++++++
 rtl/uc_multiciclo_if.sv | 31 +++
 rtl/uc_decoder.sv | 28 ++
 rtl/uc_multiciclo.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state enum, the opcode-class enum, the opcode and alu_cmd
// encodings, the registered control-output bundle and two small helpers:
// the branch-condition evaluator and the Moore output decoder.
package uc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // CLS_NONE is the reset value and the class recorded for an illegal opcode.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JAL    = 3'd6,
    CLS_LUI    = 3'd7
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_UJ = 4'b0101;

  typedef struct packed {
    logic       d_mem_we;
    logic       rf_we;
    logic       pc_we;
    logic       pc_src;
    logic       rf_src;
    logic       alu_src;
    logic       halted;
    logic [3:0] alu_cmd;
  } ctrl_t;

  // Branch condition from funct3 and the ALU zero/MSB flags.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic zero,
                                        input logic msb);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = !zero;
      3'b100:  t = msb;
      3'b101:  t = !msb;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Moore outputs for a given state, registered class and latched taken bit.
  function automatic ctrl_t ctrl_decode(input state_t st,
                                        input op_class_t cls,
                                        input logic taken);
    ctrl_t c;
    logic  alu_phase;
    c = '0;
    alu_phase = (st == ST_DECODE) || (st == ST_EXEC) ||
                (st == ST_MEM)    || (st == ST_WB);
    if (alu_phase) begin
      case (cls)
        CLS_R:      begin c.alu_cmd = ALU_R;  c.alu_src = 1'b0; end
        CLS_I,
        CLS_LOAD:   begin c.alu_cmd = ALU_I;  c.alu_src = 1'b1; end
        CLS_STORE:  begin c.alu_cmd = ALU_S;  c.alu_src = 1'b1; end
        CLS_BRANCH: begin c.alu_cmd = ALU_SB; c.alu_src = 1'b0; end
        CLS_LUI:    begin c.alu_cmd = ALU_U;  c.alu_src = 1'b1; end
        CLS_JAL:    begin c.alu_cmd = ALU_UJ; c.alu_src = 1'b1; end
        default:    begin c.alu_cmd = ALU_R;  c.alu_src = 1'b0; end
      endcase
    end else begin
      c.alu_cmd = ALU_R;
      c.alu_src = 1'b0;
    end
    c.d_mem_we = (st == ST_MEM) && (cls == CLS_STORE);
    c.rf_src   = ((st == ST_MEM) || (st == ST_WB)) && (cls == CLS_LOAD);
    c.pc_we    = (st == ST_WB);
    c.rf_we    = (st == ST_WB) && (cls != CLS_STORE) &&
                 (cls != CLS_BRANCH) && (cls != CLS_NONE);
    c.pc_src   = (st == ST_WB) &&
                 ((cls == CLS_JAL) || ((cls == CLS_BRANCH) && taken));
    c.halted   = (st == ST_HALT);
    return c;
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control-unit <-> datapath bundle.
// master (control unit): receives opcode/funct3/alu_flags from the datapath,
//                        drives the enables, mux selects, alu_cmd, halted and
//                        the retired-instruction counter.
// slave  (datapath):     the mirror image.
interface uc_multiciclo_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  alu_flags;
  logic        d_mem_we;
  logic        rf_we;
  logic [3:0]  alu_cmd;
  logic        alu_src;
  logic        pc_src;
  logic        rf_src;
  logic        pc_we;
  logic        halted;
  logic [31:0] instret;

  modport master (
    input  opcode, funct3, alu_flags,
    output d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_we,
           halted, instret
  );

  modport slave (
    output opcode, funct3, alu_flags,
    input  d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_we,
           halted, instret
  );
endinterface

// File: rtl/uc_decoder.sv
// Combinational opcode classifier.
// Ports: opcode (in, 7b) -> op_class (class enum), illegal (1 for any
// opcode outside the supported set).
module uc_decoder
  import uc_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);

  // Map the opcode to its class; anything unknown is flagged illegal.
  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_LUI:    op_class = CLS_LUI;
      default:   illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH,
// with an absorbing HALT on illegal opcodes.
// Ports: clk, rst (async, active-high); bus (master modport) carries
// opcode/funct3/alu_flags in and all control outputs plus instret out.
// MEM_WAIT (1..15) sets the number of MEM cycles for loads and stores.
// All outputs come straight from registers; they are computed from the next
// state and next registered class, so alu_flags only reach an output through
// the taken flop.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  uc_multiciclo_if.master  bus
);

  localparam logic [3:0] MEM_CNT_INIT = 4'(MEM_WAIT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  op_class_t   class_r;
  op_class_t   class_nxt_s;
  op_class_t   dec_class_s;
  logic        dec_illegal_s;
  logic [2:0]  funct3_r;
  logic        taken_r;
  logic        taken_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [31:0] instret_r;
  ctrl_t       ctrl_r;
  logic        unused_flags_s;

  uc_decoder u_decoder (
    .opcode   (bus.opcode),
    .op_class (dec_class_s),
    .illegal  (dec_illegal_s)
  );

  // Flag bits 2..3 carry no meaning for this unit.
  assign unused_flags_s = ^bus.alu_flags[3:2];

  // Next-state, class capture, branch decision and MEM wait counter.
  always_comb begin
    state_nxt_s = state_r;
    class_nxt_s = class_r;
    taken_nxt_s = taken_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_FETCH: begin
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        class_nxt_s = dec_class_s;
        taken_nxt_s = 1'b0;
        if (dec_illegal_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (class_r == CLS_BRANCH) begin
          taken_nxt_s = branch_taken(funct3_r, bus.alu_flags[0],
                                     bus.alu_flags[1]);
        end else begin
          taken_nxt_s = 1'b0;
        end
        if ((class_r == CLS_LOAD) || (class_r == CLS_STORE)) begin
          state_nxt_s = ST_MEM;
          cnt_nxt_s   = MEM_CNT_INIT;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_WB;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_WB: begin
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // State, registered instruction fields, retire counter and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      class_r   <= CLS_NONE;
      funct3_r  <= 3'd0;
      taken_r   <= 1'b0;
      cnt_r     <= 4'd0;
      instret_r <= 32'd0;
      ctrl_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      class_r <= class_nxt_s;
      taken_r <= taken_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (state_r == ST_DECODE) begin
        funct3_r <= bus.funct3;
      end
      // Retire on leaving WB; wraps naturally at 2^32.
      if (state_r == ST_WB) begin
        instret_r <= instret_r + 32'd1;
      end
      ctrl_r <= ctrl_decode(state_nxt_s, class_nxt_s, taken_nxt_s);
    end
  end

  assign bus.d_mem_we = ctrl_r.d_mem_we;
  assign bus.rf_we    = ctrl_r.rf_we;
  assign bus.pc_we    = ctrl_r.pc_we;
  assign bus.pc_src   = ctrl_r.pc_src;
  assign bus.rf_src   = ctrl_r.rf_src;
  assign bus.alu_src  = ctrl_r.alu_src;
  assign bus.halted   = ctrl_r.halted;
  assign bus.alu_cmd  = ctrl_r.alu_cmd;
  assign bus.instret  = instret_r;

endmodule
